// File: rtl/sme_cmd_feeder.sv
// Command-stream front end for the string-matching engine: parses S/P lines,
// buffers them, and replays string+pattern as one gap-free burst.
`timescale 1ns/1ps
module sme_cmd_feeder #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       sme_valid,
  output logic       busy,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int SLEN_W  = $clog2(STR_MAX + 2);
  localparam int PLEN_W  = $clog2(PAT_MAX + 2);
  localparam int SADDR_W = $clog2(STR_MAX);
  localparam int PADDR_W = $clog2(PAT_MAX);

  localparam logic [7:0] CH_S  = 8'h53;
  localparam logic [7:0] CH_P  = 8'h50;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;

  localparam logic [SLEN_W-1:0] S_MAX  = SLEN_W'(STR_MAX);
  localparam logic [SLEN_W-1:0] S_SAT  = SLEN_W'(STR_MAX + 1);
  localparam logic [PLEN_W-1:0] P_MAX  = PLEN_W'(PAT_MAX);
  localparam logic [PLEN_W-1:0] P_SAT  = PLEN_W'(PAT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, COL_S, COL_P, DISCARD, EMIT_S, EMIT_P, WAIT_RES
  } state_t;

  state_t state_q, state_d;

  logic [SLEN_W-1:0] slen_q, slen_d;
  logic [SLEN_W-1:0] str_len_q, str_len_d;
  logic [SLEN_W-1:0] idx_q, idx_d;
  logic [PLEN_W-1:0] plen_q, plen_d;
  logic              sovf_q, sovf_d;
  logic              povf_q, povf_d;
  logic              str_pend_q, str_pend_d;
  logic              str_loaded_q, str_loaded_d;
  logic              bank_q, bank_d;
  logic [7:0]        chardata_q, chardata_d;
  logic              isstring_q, isstring_d;
  logic              ispattern_q, ispattern_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;

  // Two string banks: a line is collected into the spare bank so a rejected
  // line never disturbs the string that is already committed.
  logic [7:0] sbuf [0:2*STR_MAX-1];
  logic [7:0] pbuf [0:PAT_MAX-1];

  logic               accept;
  logic               is_payload;
  logic               s_we, p_we;
  logic [SADDR_W:0]   s_waddr, s_raddr;
  logic [PADDR_W-1:0] p_waddr, p_raddr;
  logic [7:0]         s_rdata, p_rdata;

  assign in_ready   = (state_q == IDLE) || (state_q == COL_S) ||
                      (state_q == COL_P) || (state_q == DISCARD);
  assign busy       = (state_q == EMIT_S) || (state_q == EMIT_P) ||
                      (state_q == WAIT_RES);
  assign accept     = in_valid && in_ready;
  assign is_payload = accept && (in_data != CH_LF) && (in_data != CH_CR);

  assign s_we    = (state_q == COL_S) && is_payload && (slen_q < S_MAX);
  assign p_we    = (state_q == COL_P) && is_payload && (plen_q < P_MAX);
  assign s_waddr = {~bank_q, slen_q[SADDR_W-1:0]};
  assign s_raddr = {bank_q, idx_q[SADDR_W-1:0]};
  assign p_waddr = plen_q[PADDR_W-1:0];
  assign p_raddr = idx_q[PADDR_W-1:0];
  assign s_rdata = sbuf[s_raddr];
  assign p_rdata = pbuf[p_raddr];

  always_ff @(posedge clk) begin
    if (s_we) begin
      sbuf[s_waddr] <= in_data;
    end
    if (p_we) begin
      pbuf[p_waddr] <= in_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    slen_d       = slen_q;
    str_len_d    = str_len_q;
    idx_d        = idx_q;
    plen_d       = plen_q;
    sovf_d       = sovf_q;
    povf_d       = povf_q;
    str_pend_d   = str_pend_q;
    str_loaded_d = str_loaded_q;
    bank_d       = bank_q;
    chardata_d   = 8'h00;
    isstring_d   = 1'b0;
    ispattern_d  = 1'b0;
    err_d        = 1'b0;
    err_code_d   = err_code_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_data == CH_S) begin
            state_d = COL_S;
            slen_d  = '0;
            sovf_d  = 1'b0;
          end else if (in_data == CH_P) begin
            state_d = COL_P;
            plen_d  = '0;
            povf_d  = 1'b0;
          end else if ((in_data == CH_LF) || (in_data == CH_CR)) begin
            state_d = IDLE;
          end else begin
            state_d    = DISCARD;
            err_d      = 1'b1;
            err_code_d = 2'd0;
          end
        end
      end

      DISCARD: begin
        if (accept && (in_data == CH_LF)) begin
          state_d = IDLE;
        end
      end

      COL_S: begin
        if (accept && (in_data == CH_LF)) begin
          state_d = IDLE;
          if ((slen_q == '0) || sovf_q) begin
            err_d      = 1'b1;
            err_code_d = 2'd1;
          end else begin
            str_len_d    = slen_q;
            bank_d       = ~bank_q;
            str_pend_d   = 1'b1;
            str_loaded_d = 1'b1;
          end
        end else if (is_payload) begin
          if (slen_q < S_MAX) begin
            slen_d = slen_q + SLEN_W'(1);
          end else begin
            slen_d = S_SAT;
            sovf_d = 1'b1;
          end
        end
      end

      COL_P: begin
        if (accept && (in_data == CH_LF)) begin
          if ((plen_q == '0) || povf_q) begin
            state_d    = IDLE;
            err_d      = 1'b1;
            err_code_d = 2'd2;
          end else if (!str_loaded_q) begin
            state_d    = IDLE;
            err_d      = 1'b1;
            err_code_d = 2'd3;
          end else begin
            idx_d   = '0;
            state_d = str_pend_q ? EMIT_S : EMIT_P;
          end
        end else if (is_payload) begin
          if (plen_q < P_MAX) begin
            plen_d = plen_q + PLEN_W'(1);
          end else begin
            plen_d = P_SAT;
            povf_d = 1'b1;
          end
        end
      end

      EMIT_S: begin
        isstring_d = 1'b1;
        chardata_d = s_rdata;
        str_pend_d = 1'b0;
        if (idx_q == str_len_q - SLEN_W'(1)) begin
          idx_d   = '0;
          state_d = EMIT_P;
        end else begin
          idx_d = idx_q + SLEN_W'(1);
        end
      end

      EMIT_P: begin
        ispattern_d = 1'b1;
        chardata_d  = p_rdata;
        if (idx_q[PLEN_W-1:0] == plen_q - PLEN_W'(1)) begin
          idx_d   = '0;
          state_d = WAIT_RES;
        end else begin
          idx_d = idx_q + SLEN_W'(1);
        end
      end

      WAIT_RES: begin
        if (sme_valid) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      slen_q       <= '0;
      str_len_q    <= '0;
      idx_q        <= '0;
      plen_q       <= '0;
      sovf_q       <= 1'b0;
      povf_q       <= 1'b0;
      str_pend_q   <= 1'b0;
      str_loaded_q <= 1'b0;
      bank_q       <= 1'b0;
      chardata_q   <= 8'h00;
      isstring_q   <= 1'b0;
      ispattern_q  <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= 2'd0;
    end else begin
      state_q      <= state_d;
      slen_q       <= slen_d;
      str_len_q    <= str_len_d;
      idx_q        <= idx_d;
      plen_q       <= plen_d;
      sovf_q       <= sovf_d;
      povf_q       <= povf_d;
      str_pend_q   <= str_pend_d;
      str_loaded_q <= str_loaded_d;
      bank_q       <= bank_d;
      chardata_q   <= chardata_d;
      isstring_q   <= isstring_d;
      ispattern_q  <= ispattern_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign chardata  = chardata_q;
  assign isstring  = isstring_q;
  assign ispattern = ispattern_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_sme_cmd_feeder.sv
// Scoreboard bench for sme_cmd_feeder: a small line model predicts the burst
// contents, a negedge monitor pops and compares every strobe cycle.
`timescale 1ns/1ps
module tb_sme_cmd_feeder;

  typedef logic [7:0] bytes_t[$];

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       sme_valid;
  logic       busy;
  logic       err;
  logic [1:0] err_code;

  sme_cmd_feeder dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .chardata  (chardata),
    .isstring  (isstring),
    .ispattern (ispattern),
    .sme_valid (sme_valid),
    .busy      (busy),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard entries: bit 8 = pattern strobe, bits 7:0 = character.
  logic [8:0] exp_q[$];
  bytes_t     m_str;
  bit         m_pend   = 1'b0;
  bit         m_loaded = 1'b0;
  int         exp_errs = 0;
  int         err_seen = 0;
  int         bursts   = 0;
  int         first_cyc = 0;
  int         last_cyc  = 0;
  bit         prev_strobe = 1'b0;

  always @(negedge clk) begin
    logic [8:0] e;
    if (!reset) begin
      if (err) err_seen++;
      if (isstring && ispattern) check_val("both_strobes", 32'd1, 32'd0);
      if (isstring || ispattern) begin
        if (!prev_strobe) begin
          bursts++;
          first_cyc = cyc;
        end
        last_cyc = cyc;
        check_val("strobe_busy", 32'(busy), 32'd1);
        if (exp_q.size() == 0) begin
          check_val("unexpected_strobe", 32'({isstring, ispattern, chardata}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_val("strobe_kind", 32'({isstring, ispattern}), e[8] ? 32'd1 : 32'd2);
          check_val("strobe_char", 32'(chardata), 32'(e[7:0]));
        end
      end else begin
        check_val("idle_chardata", 32'(chardata), 32'd0);
      end
      prev_strobe = isstring || ispattern;
    end else begin
      prev_strobe = 1'b0;
    end
  end

  function automatic bytes_t to_bytes(input string s);
    bytes_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic bytes_t make_seq(input int n);
    bytes_t q;
    for (int i = 0; i < n; i++) q.push_back(8'(8'h41 + (i % 26)));
    return q;
  endfunction

  function automatic bytes_t strip_cr(input bytes_t p);
    bytes_t q;
    foreach (p[i]) if (p[i] != 8'h0D) q.push_back(p[i]);
    return q;
  endfunction

  // Returns one cycle into the cycle after acceptance; acc = cycle of acceptance.
  task automatic send_byte(input logic [7:0] b, output int acc);
    int guard;
    guard = 0;
    @(posedge clk);
    #1;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check_val("in_ready_timeout", 32'(in_ready), 32'd1);
    acc = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_line(input logic [7:0] cmd, input bytes_t p, output int lf_acc);
    int a;
    send_byte(cmd, a);
    foreach (p[i]) send_byte(p[i], a);
    send_byte(8'h0A, lf_acc);
  endtask

  task automatic s_line(input bytes_t p);
    bytes_t c;
    bit     bad;
    int     lf;
    c   = strip_cr(p);
    bad = (c.size() == 0) || (c.size() > 32);
    send_line(8'h53, p, lf);
    @(negedge clk);
    check_val("s_line_err", 32'(err), 32'(bad));
    if (bad) begin
      check_val("s_line_code", 32'(err_code), 32'd1);
      exp_errs++;
    end else begin
      m_str    = c;
      m_pend   = 1'b1;
      m_loaded = 1'b1;
    end
    $display("S line len=%0d accepted=%0d", c.size(), !bad);
  endtask

  task automatic wait_res_phase();
    in_data  = 8'h51;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_val("wait_in_ready", 32'(in_ready), 32'd0);
      check_val("wait_busy", 32'(busy), 32'd1);
    end
    @(posedge clk);
    #1;
    sme_valid = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk);
    #1;
    sme_valid = 1'b0;
    @(negedge clk);
    check_val("post_valid_ready", 32'(in_ready), 32'd1);
    check_val("post_valid_busy", 32'(busy), 32'd0);
  endtask

  task automatic p_line(input bytes_t p);
    bytes_t c;
    bit     bad_len, burst;
    int     lf, n_exp, b0, guard;
    c       = strip_cr(p);
    bad_len = (c.size() == 0) || (c.size() > 8);
    burst   = !bad_len && m_loaded;
    n_exp   = 0;
    if (burst) begin
      if (m_pend) foreach (m_str[i]) exp_q.push_back({1'b0, m_str[i]});
      foreach (c[i]) exp_q.push_back({1'b1, c[i]});
      n_exp = exp_q.size();
    end
    b0 = bursts;
    send_line(8'h50, p, lf);
    @(negedge clk);
    check_val("p_line_err", 32'(err), 32'(!burst));
    if (!burst) begin
      check_val("p_line_code", 32'(err_code), bad_len ? 32'd2 : 32'd3);
      exp_errs++;
      repeat (3) @(negedge clk);
      check_val("p_err_no_burst", 32'(bursts - b0), 32'd0);
    end else begin
      m_pend = 1'b0;
      guard  = 0;
      while (exp_q.size() != 0 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (exp_q.size() != 0) begin
        check_val("burst_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
      end
      check_val("burst_latency", 32'(first_cyc - lf), 32'd2);
      check_val("burst_length", 32'(last_cyc - first_cyc + 1), 32'(n_exp));
      check_val("burst_count", 32'(bursts - b0), 32'd1);
      wait_res_phase();
    end
    $display("P line len=%0d burst=%0d strobes=%0d", c.size(), burst, n_exp);
  endtask

  initial begin
    int  a, guard;
    reset     = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    sme_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_strobes", 32'({isstring, ispattern}), 32'd0);
    check_val("rst_chardata", 32'(chardata), 32'd0);
    check_val("rst_err", 32'({err, err_code}), 32'd0);

    s_line(to_bytes("abc"));
    p_line(to_bytes("bc"));
    p_line(to_bytes("x"));

    s_line(make_seq(33));
    p_line(to_bytes("ab"));

    s_line(to_bytes("def"));
    s_line(make_seq(33));
    p_line(to_bytes("e"));

    p_line(to_bytes("abcdefghi"));
    p_line(to_bytes(""));
    s_line(to_bytes(""));

    send_byte(8'h51, a);
    @(negedge clk);
    check_val("discard_err", 32'(err), 32'd1);
    check_val("discard_code", 32'(err_code), 32'd0);
    exp_errs++;
    send_byte(8'h7A, a);
    send_byte(8'h7A, a);
    send_byte(8'h0A, a);
    @(negedge clk);
    check_val("discard_tail_err", 32'(err), 32'd0);
    $display("Q line discarded");

    s_line(to_bytes("hel\rlo"));
    p_line(to_bytes("l\ro"));

    s_line(to_bytes("aaaa"));
    s_line(to_bytes("xy"));
    p_line(to_bytes("z"));

    s_line(make_seq(32));
    p_line(make_seq(8));

    // Reset in the middle of a string burst.
    s_line(to_bytes("0123456789"));
    foreach (m_str[i]) exp_q.push_back({1'b0, m_str[i]});
    exp_q.push_back({1'b1, 8'h61});
    send_line(8'h50, to_bytes("a"), a);
    guard = 0;
    while (!isstring && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_val("pre_reset_isstring", 32'(isstring), 32'd1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_val("mid_rst_strobes", 32'({isstring, ispattern}), 32'd0);
    check_val("mid_rst_chardata", 32'(chardata), 32'd0);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    m_pend   = 1'b0;
    m_loaded = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    $display("reset asserted mid burst");

    p_line(to_bytes("a"));
    s_line(to_bytes("ok"));
    p_line(to_bytes("k"));

    repeat (4) @(negedge clk);
    check_val("err_pulse_count", 32'(err_seen), 32'(exp_errs));
    check_val("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sme_cmd_feeder.md
# sme_cmd_feeder

Upstream front end for the string-matching engine (SME). It parses a byte-wide command stream of newline-terminated `S` (string) and `P` (pattern) lines and buffers each line. It replays buffered data to the SME as contiguous `isstring`/`ispattern` bursts, with the string burst immediately followed by the pattern burst. It then holds off further input until the SME returns `valid`.

## Interface
- `STR_MAX`, 32: maximum string length in characters.
- `PAT_MAX`, 8: maximum pattern length in characters.

- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `in_data`  in  8  command-stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  the feeder accepts a byte this cycle. Combinational from state.
- `chardata`  out  8  character to the SME. Registered.
- `isstring`  out  1  string character strobe to the SME. Registered.
- `ispattern`  out  1  pattern character strobe to the SME. Registered.
- `sme_valid`  in  1  SME result-valid strobe.
- `busy`  out  1  high in EMIT and WAIT_RES.
- `err`  out  1  one-cycle error pulse.
- `err_code`  out  2  error cause; holds its value until the next `err`.

## Operation
- A byte is accepted when `in_valid && in_ready`.
- Line format:
  - The first byte is the command: `S` (0x53) or `P` (0x50).
  - Payload bytes follow, terminated by LF (0x0A).
  - CR (0x0D) is discarded anywhere in a line.
- FSM states: IDLE, COL_S, COL_P, DISCARD, EMIT_S, EMIT_P, WAIT_RES.
- IDLE transitions:
  - `S` → COL_S, and the string length counter is cleared.
  - `P` → COL_P, and the pattern length counter is cleared.
  - LF → stays in IDLE (empty line, ignored).
  - Any other byte → DISCARD with `err`, `err_code`=0.
- DISCARD: consumes bytes until LF, then goes to IDLE.
- COL_S:
  - Each byte is written to `sbuf[slen]` and `slen` increments. `slen` is 6 bits and saturates at 33.
  - Bytes beyond `STR_MAX` are dropped and set `sovf`.
  - On LF: if `slen` is 0 or `sovf` is set → `err`, `err_code`=1, and the previous pending string is kept. Otherwise the new string is committed: `str_pend`=1 and `str_loaded`=1. Then go to IDLE.
  - A committed string is not sent yet. The SME requires the pattern to follow the string with no gap.
- COL_P: same rules as COL_S, with `plen` (4 bits) and `PAT_MAX`. On LF:
  - Bad length → `err`, `err_code`=2, go to IDLE.
  - `str_loaded`=0 → `err`, `err_code`=3, go to IDLE.
  - `str_pend`=1 → EMIT_S.
  - Otherwise → EMIT_P. The SME reuses the string it already holds.
- EMIT_S:
  - Drives `isstring`=1 with `chardata`=`sbuf[i]` for exactly `slen` consecutive cycles.
  - The last string cycle is followed directly by the first pattern cycle in EMIT_P.
  - `str_pend` clears.
- EMIT_P: drives `ispattern`=1 with `chardata`=`pbuf[j]` for exactly `plen` cycles, then goes to WAIT_RES.
- WAIT_RES: waits for `sme_valid`=1, then goes to IDLE.
- `in_ready` is 1 in IDLE, COL_S, COL_P and DISCARD, and 0 otherwise.
- `isstring` and `ispattern` are never high in the same cycle.
- When neither strobe is high, `chardata` is 0.
- A new `S` line that arrives while a string is still pending overwrites it, last-wins.

## Timing
- Reset values: `in_ready`=1 (state IDLE), and all other outputs are 0. `str_pend`, `str_loaded`, `slen`, `plen` and both buffers' indices are 0.
- Latency: the LF of a P line is accepted in cycle T. The first `isstring` or `ispattern` is high in cycle T+2: T+1 is the state change, and the registered outputs appear at T+2.
- Burst lengths:
  - `isstring` is high for exactly `slen` cycles.
  - `ispattern` is high for exactly `plen` cycles, starting the cycle after the last `isstring`.
- `err` is high the cycle after the offending LF or command byte is accepted.
- `sme_valid` is sampled only in WAIT_RES and ignored in every other state.
- `sme_valid` seen in cycle V → state is IDLE and `in_ready`=1 at V+1. This guarantees at least one idle cycle before the next burst.
- Reset during EMIT: outputs go to 0 immediately, and the buffered string and pattern are lost.

## Test plan
- `S`"abc"LF then `P`"bc"LF → `isstring` for 3 cycles carrying 0x61, 0x62, 0x63, then `ispattern` for 2 cycles carrying 0x62, 0x63, with no gap. `busy`=1 until `sme_valid`.
- A second `P`"x"LF after `sme_valid` → only `ispattern` for 1 cycle carrying 0x78; `isstring` stays 0.
- A `S` line of 33 chars then LF → `err` with `err_code`=1. A following P line uses the previous string; with none loaded → `err_code`=3.
- `P`"abcdefghi"LF (9 chars) → `err` with `err_code`=2, and no strobes are driven.
- Byte `Q`, then "zz", then LF → `err` with `err_code`=0, the line is discarded, and the next valid S/P lines work normally.
- `in_valid` held high during WAIT_RES → `in_ready`=0 and no bytes are consumed. Assert `reset` mid EMIT_S → all outputs are 0 in the same cycle.
